// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM state codes, error codes,
// RV32 load/store funct3 encodings and the alignment check helper.
package lsu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LD_MIS  = 2'd1;
    localparam logic [1:0] ERR_ST_MIS  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] is the access size: 00 byte, 01 half, 1x word
    // (so 011/110/111 fall into the word case).
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store strobes and data replication, load shift and
// sign/zero extension. Purely combinational.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata
);

    logic [1:0]  eoff;
    logic [15:0] w;

    // Decode lanes by access size; halfwords only honour off[1] and words
    // ignore the offset, so unchecked misaligned accesses stay in-word.
    always_comb begin
        eoff      = 2'b00;
        strb      = 4'b1111;
        wdata_rep = wdata;
        ldata     = rdata;
        w         = 16'h0;
        case (funct3[1:0])
            2'b00: begin
                eoff      = off;
                strb      = 4'b0001 << eoff;
                wdata_rep = {4{wdata[7:0]}};
                w         = 16'(rdata >> {eoff, 3'b000});
                ldata     = funct3[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            end
            2'b01: begin
                eoff      = {off[1], 1'b0};
                strb      = 4'b0011 << eoff;
                wdata_rep = {2{wdata[15:0]}};
                w         = 16'(rdata >> {eoff, 3'b000});
                ldata     = funct3[2] ? {16'h0, w} : {{16{w[15]}}, w};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: request capture, IDLE/REQ/WAIT/RESP FSM,
// memory port drive, load result capture and timeout abort.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses without touching memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    input  logic        in_load,
    input  logic        in_store,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [1:0]  out_err
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_f3;
    logic        cap_we;
    logic [31:0] result;
    logic [1:0]  err;
    logic [15:0] tcnt;
    logic        mis;
    logic [3:0]  strb;
    logic [31:0] wrep;
    logic [31:0] ldata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = (in_load | in_store) & misaligned(in_funct3, in_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    lsu_lane u_lane (
        .funct3    (cap_f3),
        .off       (cap_addr[1:0]),
        .wdata     (cap_wdata),
        .rdata     (mem_rdata),
        .strb      (strb),
        .wdata_rep (wrep),
        .ldata     (ldata)
    );

    // Every output is decoded from state or captured registers only.
    assign in_ready  = (state == S_IDLE);
    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req & cap_we;
    assign mem_addr  = {cap_addr[31:2], 2'b00};
    assign mem_wdata = wrep;
    assign mem_wstrb = mem_we ? strb : 4'b0000;
    assign out_valid = (state == S_RESP);
    assign out_rdata = result;
    assign out_err   = err;

    // FSM, request capture, timeout counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cap_addr  <= 32'h0;
            cap_wdata <= 32'h0;
            cap_f3    <= 3'b000;
            cap_we    <= 1'b0;
            result    <= 32'h0;
            err       <= ERR_NONE;
            tcnt      <= 16'h0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    cap_addr  <= in_addr;
                    cap_wdata <= in_wdata;
                    cap_f3    <= in_funct3;
                    cap_we    <= in_store & ~in_load;
                    result    <= 32'h0;
                    tcnt      <= 16'h0;
                    if (mis) begin
                        err   <= in_load ? ERR_LD_MIS : ERR_ST_MIS;
                        state <= S_RESP;
                    end else begin
                        err   <= ERR_NONE;
                        state <= (in_load | in_store) ? S_REQ : S_RESP;
                    end
                end
                S_REQ: begin
                    tcnt <= tcnt + 16'd1;
                    if (mem_gnt) begin
                        state <= S_WAIT;
                    end else if (tcnt == TO_LAST) begin
                        err   <= ERR_TIMEOUT;
                        state <= S_RESP;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt + 16'd1;
                    if (mem_rvalid) begin
                        result <= cap_we ? 32'h0 : ldata;
                        state  <= S_RESP;
                    end else if (tcnt == TO_LAST) begin
                        err   <= ERR_TIMEOUT;
                        state <= S_RESP;
                    end
                end
                default: if (out_ready) state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written
// timeout and reset sequences, then randomized traffic against a
// byte-level reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic [2:0]  in_funct3 = 3'b000;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic [1:0]  out_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_funct3(in_funct3), .in_load(in_load),
        .in_store(in_store),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_err(out_err)
    );

    typedef struct {
        logic [31:0] addr, wdata, raw;
        logic [2:0]  f3;
        logic        ld, st;
        int          gd, yd;
        logic        acc, we;
        logic [3:0]  strb;
        logic [31:0] ewd, erd;
        logic [1:0]  err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [31:0] addr, logic [31:0] wdata, logic [31:0] raw,
                                logic [2:0] f3, logic ld, logic st, int gd, int yd,
                                logic acc, logic we, logic [3:0] strb,
                                logic [31:0] ewd, logic [31:0] erd, logic [1:0] err);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.raw = raw; v.f3 = f3; v.ld = ld; v.st = st;
        v.gd = gd; v.yd = yd; v.acc = acc; v.we = we; v.strb = strb;
        v.ewd = ewd; v.erd = erd; v.err = err;
        return v;
    endfunction

    // Reference model: access of n bytes at the offset rounded down to a
    // multiple of n; byte i of the store bus carries source byte i mod n.
    task automatic model(inout vec_t v);
        int n, off, eo;
        logic [31:0] mask, val;
        n   = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(v.addr[1:0]);
        eo  = (off / n) * n;
        v.acc = v.ld | v.st;
        v.we  = v.st & ~v.ld;
        v.err = 2'd0; v.strb = 4'h0; v.ewd = 32'h0; v.erd = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (v.acc && (off % n) != 0) begin
            v.err = v.ld ? 2'd1 : 2'd2;
            v.acc = 1'b0;
        end
`endif
        if (v.acc) begin
            for (int i = 0; i < 4; i++) begin
                if (v.we && i >= eo && i < eo + n) v.strb[i] = 1'b1;
                v.ewd[8*i +: 8] = v.wdata[8*(i % n) +: 8];
            end
            if (!v.we) begin
                mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
                val  = (v.raw >> (8 * eo)) & mask;
                if (!v.f3[2] && n < 4 && val[8*n-1]) val = val | ~mask;
                v.erd = val;
            end
        end
    endtask

    task automatic accept(input vec_t v);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("in_ready_idle", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1; in_addr = v.addr; in_wdata = v.wdata;
        in_funct3 = v.f3; in_load = v.ld; in_store = v.st;
        @(negedge clk);
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
        in_funct3 = 3'($urandom); in_load = 1'($urandom); in_store = 1'($urandom);
    endtask

    task automatic run(input vec_t v, input int rd);
        accept(v);
        if (v.acc) begin
            for (int g = 0; g <= v.gd; g++) begin
                chk("mem_req", {31'h0, mem_req}, 32'h1);
                chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                chk("mem_we", {31'h0, mem_we}, {31'h0, v.we});
                chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, v.strb});
                if (v.we) chk("mem_wdata", mem_wdata, v.ewd);
                chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
                mem_gnt = (g == v.gd);
                mem_rvalid = 1'($urandom);
                mem_rdata = $urandom;
                @(negedge clk);
            end
            mem_gnt = 1'b0;
            for (int r = 0; r <= rd; r++) begin
                chk("mem_req_wait", {31'h0, mem_req}, 32'h0);
                chk("out_valid_wait", {31'h0, out_valid}, 32'h0);
                mem_rvalid = (r == rd);
                mem_rdata = (r == rd) ? v.raw : $urandom;
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
        end
        for (int y = 0; y <= v.yd; y++) begin
            chk("out_valid", {31'h0, out_valid}, 32'h1);
            chk("out_rdata", out_rdata, v.erd);
            chk("out_err", {30'h0, out_err}, {30'h0, v.err});
            chk("mem_req_resp", {31'h0, mem_req}, 32'h0);
            chk("in_ready_resp", {31'h0, in_ready}, 32'h0);
            out_ready = (y == v.yd);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("out_valid_done", {31'h0, out_valid}, 32'h0);
        chk("in_ready_done", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        vec_t v;
        int cnt;
        logic [2:0] f3s [8];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        tbl[0]  = mk(32'h8000_0003, 32'h1234_56AB, 32'h0, 3'b000, 0, 1, 0, 0, 1, 1, 4'b1000, 32'hABAB_ABAB, 32'h0, 2'd0);
        tbl[1]  = mk(32'h0000_1002, 32'h0, 32'h8001_0000, 3'b001, 1, 0, 3, 2, 1, 0, 4'h0, 32'h0, 32'hFFFF_8001, 2'd0);
        tbl[2]  = mk(32'h0000_1002, 32'h0, 32'h8001_0000, 3'b101, 1, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0000_8001, 2'd0);
        tbl[3]  = mk(32'h0000_0001, 32'h0, 32'h0000_F000, 3'b000, 1, 0, 1, 0, 1, 0, 4'h0, 32'h0, 32'hFFFF_FFF0, 2'd0);
        tbl[4]  = mk(32'h0000_0003, 32'h0, 32'h8000_0000, 3'b100, 1, 0, 0, 1, 1, 0, 4'h0, 32'h0, 32'h0000_0080, 2'd0);
        tbl[5]  = mk(32'h0000_0002, 32'hFFFF_BEEF, 32'h0, 3'b001, 0, 1, 0, 0, 1, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 2'd0);
        tbl[6]  = mk(32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 3'b010, 0, 1, 2, 0, 1, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 2'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[7]  = mk(32'h0000_0101, 32'h0, 32'hCAFE_F00D, 3'b010, 1, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd1);
        tbl[8]  = mk(32'h0000_0201, 32'h0000_1234, 32'h0, 3'b001, 0, 1, 0, 1, 0, 1, 4'h0, 32'h0, 32'h0, 2'd2);
`else
        tbl[7]  = mk(32'h0000_0101, 32'h0, 32'hCAFE_F00D, 3'b010, 1, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'hCAFE_F00D, 2'd0);
        tbl[8]  = mk(32'h0000_0201, 32'h0000_1234, 32'h0, 3'b001, 0, 1, 0, 1, 1, 1, 4'b0011, 32'h1234_1234, 32'h0, 2'd0);
`endif
        tbl[9]  = mk(32'h0000_0044, 32'h5555_5555, 32'h0, 3'b010, 0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0);
        tbl[10] = mk(32'h0000_0020, 32'h7777_7777, 32'h1122_3344, 3'b010, 1, 1, 0, 0, 1, 0, 4'h0, 32'h0, 32'h1122_3344, 2'd0);
        tbl[11] = mk(32'h0000_0008, 32'h0, 32'hA1B2_C3D4, 3'b011, 1, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'hA1B2_C3D4, 2'd0);
        tbl[12] = mk(32'h0000_000C, 32'h0102_0304, 32'h0, 3'b110, 0, 1, 1, 0, 1, 1, 4'b1111, 32'h0102_0304, 32'h0, 2'd0);

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_rdata", out_rdata, 32'h0);
        chk("rst_out_err", {30'h0, out_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 13; i++) run(tbl[i], (i == 1) ? 1 : 0);

        // Timeout: never grant
        v = mk(32'h0000_0040, 32'h0, 32'h0, 3'b010, 1, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 2'd0);
        accept(v);
        cnt = 0;
        for (int i = 0; i < 20 && mem_req === 1'b1; i++) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", cnt, 8);
        chk("timeout_out_valid", {31'h0, out_valid}, 32'h1);
        chk("timeout_out_err", {30'h0, out_err}, 32'h3);
        chk("timeout_out_rdata", out_rdata, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("timeout_idle", {31'h0, in_ready}, 32'h1);

        // Reset while waiting for read data
        accept(v);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait_state_reached", {31'h0, mem_req}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_wait_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_wait_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while presenting a result: out_valid must drop at once
        accept(tbl[9]);
        chk("resp_before_rst", {31'h0, out_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_resp_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_resp_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(tbl[1], 0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            v.addr = $urandom; v.wdata = $urandom; v.raw = $urandom;
            v.f3 = f3s[$urandom_range(0, 7)];
            v.ld = 1'($urandom); v.st = 1'($urandom);
            if ($urandom_range(0, 3) != 0 && !v.ld && !v.st) v.ld = 1'b1;
            v.gd = $urandom_range(0, 2);
            v.yd = $urandom_range(0, 2);
            model(v);
            run(v, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
